// File: rtl/mmio_input_hub_pkg.sv
// Shared memory map for the MMIO input hub (addresses are also used by the assembler tests).
// Holds the I/O address constants, the button address table and small decode helpers.
// No logic state lives here.
package mmio_input_hub_pkg;

  localparam logic [31:0] ADDR_BTNC = 32'd1000;
  localparam logic [31:0] ADDR_OUT  = 32'd2000;
  localparam logic [31:0] ADDR_STAT = 32'd2001;
  localparam logic [31:0] ADDR_BTNL = 32'd3000;
  localparam logic [31:0] ADDR_BTNR = 32'd4000;
  localparam logic [31:0] ADDR_BTNU = 32'd5000;
  localparam logic [31:0] ADDR_BTND = 32'd6000;
  localparam logic [31:0] ADDR_SW   = 32'd7000;

  localparam int NUM_BTN = 5;

  // Index 0..4 = centre, left, right, up, down (same order as the button vector in the top).
  localparam logic [NUM_BTN-1:0][31:0] BTN_ADDRS =
    {ADDR_BTND, ADDR_BTNU, ADDR_BTNR, ADDR_BTNL, ADDR_BTNC};

  // True for any address owned by the I/O block; such accesses never reach RAM.
  function automatic logic is_io_addr(input logic [31:0] a);
    return (a == ADDR_BTNC) || (a == ADDR_OUT) || (a == ADDR_STAT) ||
           (a == ADDR_BTNL) || (a == ADDR_BTNR) || (a == ADDR_BTNU) ||
           (a == ADDR_BTND) || (a == ADDR_SW);
  endfunction

  // Status word layout: overflow at bit 15, entry count in the low byte.
  function automatic logic [31:0] stat_word(input logic ovf, input logic [7:0] cnt);
    return {16'b0, ovf, 7'b0, cnt};
  endfunction

endpackage

// File: rtl/mmio_input_hub_if.sv
// Bus bundle between the processor/RAM/VGA side and the MMIO input hub.
// slave = the hub, master = the environment driving processor, buttons and VGA ready.
// Pure wiring, no state.
interface mmio_input_hub_if;
  logic        btn_c, btn_l, btn_r, btn_u, btn_d;
  logic [3:0]  sw;
  logic [31:0] address_dmem;
  logic        wren;
  logic [31:0] data;
  logic [31:0] ram_q;
  logic [31:0] q_dmem;
  logic        ram_wren;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;

  modport slave (
    input  btn_c, btn_l, btn_r, btn_u, btn_d, sw, address_dmem, wren, data, ram_q, cmd_ready,
    output q_dmem, ram_wren, cmd_data, cmd_valid
  );

  modport master (
    output btn_c, btn_l, btn_r, btn_u, btn_d, sw, address_dmem, wren, data, ram_q, cmd_ready,
    input  q_dmem, ram_wren, cmd_data, cmd_valid
  );
endinterface

// File: rtl/mmio_input_hub_cmd_fifo.sv
// Command FIFO: registered storage, combinational head read (zero when empty).
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module mmio_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer advance for accepted push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer state; reset empties the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents are don't-care until written, head is masked when empty.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

// File: rtl/mmio_input_hub.sv
// MMIO stage: sticky button events, switch/status reads, store-to-FIFO for VGA, RAM/IO read mux.
// Latency: loads return one cycle later on both RAM and I/O paths.
// Backpressure: VGA drains via cmd_valid/cmd_ready; stores to a full FIFO are dropped and flagged.
module mmio_input_hub
  import mmio_input_hub_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic          clock,
  input logic          reset,
  mmio_input_hub_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_BTN-1:0] btn, btn_q, rise, rd_hit, pending_q, pending_d;
  logic               is_load, io_hit, btn_rd, btn_val, sw_rd, stat_rd, out_push, pop;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               overflow_q, overflow_d;
  logic               io_rd, last_ram_q;
  logic [31:0]        io_rdata_q, io_rdata_d;

  assign btn     = {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l, bus.btn_c};
  assign is_load = ~bus.wren;
  assign io_hit  = is_io_addr(bus.address_dmem);
  assign bus.ram_wren = bus.wren & ~io_hit;

  // Per-button slice: a rise sets the flag, a load clears it; a rise wins over a same-cycle clear.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    assign rise[i]      = btn[i] & ~btn_q[i];
    assign rd_hit[i]    = is_load & (bus.address_dmem == BTN_ADDRS[i]);
    assign pending_d[i] = (pending_q[i] & ~rd_hit[i]) | rise[i];
  end

  assign btn_rd   = |rd_hit;
  assign btn_val  = |(pending_q & rd_hit);
  assign sw_rd    = is_load & (bus.address_dmem == ADDR_SW);
  assign stat_rd  = is_load & (bus.address_dmem == ADDR_STAT);
  assign out_push = bus.wren & (bus.address_dmem == ADDR_OUT);
  assign pop      = ~fifo_empty & bus.cmd_ready;

  mmio_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (out_push),
    .push_dat_i (bus.data),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .head_o     (bus.cmd_data)
  );
  assign bus.cmd_valid = ~fifo_empty;

  // Sticky overflow: set by a dropped store, cleared by a status read.
  always_comb begin
    overflow_d = overflow_q;
    if (stat_rd) overflow_d = 1'b0;
    if (out_push & fifo_full & ~pop) overflow_d = 1'b1;
  end

  // I/O read data selection for the load in this cycle.
  always_comb begin
    io_rd      = 1'b0;
    io_rdata_d = '0;
    if (btn_rd) begin
      io_rd      = 1'b1;
      io_rdata_d = {31'b0, btn_val};
    end else if (sw_rd) begin
      io_rd      = 1'b1;
      io_rdata_d = {28'b0, bus.sw};
    end else if (stat_rd) begin
      io_rd      = 1'b1;
      io_rdata_d = stat_word(overflow_q, 8'(fifo_count));
    end
  end

  // Edge, pending, overflow and read-path registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      io_rdata_q <= '0;
      last_ram_q <= 1'b0;
    end else begin
      btn_q      <= btn;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      io_rdata_q <= io_rdata_d;
      last_ram_q <= ~io_rd;
    end
  end

  // RAM data already arrives one cycle late, so it bypasses the register.
  assign bus.q_dmem = last_ram_q ? bus.ram_q : io_rdata_q;
endmodule

// File: tb/tb_mmio_input_hub.sv
// Self-checking bench for mmio_input_hub: table of single-cycle load/store vectors
// followed by hand-written FIFO overflow, full+pop, empty push and reset-during-drain sequences.
// A small 1-cycle-latency RAM model supplies ram_q.
module tb_mmio_input_hub;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mmio_input_hub_if bus();

  mmio_input_hub #(.FIFO_DEPTH(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: read-before-write, one cycle of read latency.
  logic [31:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
  end
  always @(posedge clk) begin
    bus.ram_q <= ram_mem[bus.address_dmem[7:0]];
    if (bus.ram_wren) ram_mem[bus.address_dmem[7:0]] <= bus.data;
  end

  typedef struct {
    string       name;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  btn;   // {d,u,r,l,c}
    logic [3:0]  sw;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_ram_wren;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [4:0] b, input logic [3:0] s,
                              input logic c, input logic [31:0] q, input logic rw);
    vec_t v;
    v.name = n; v.wren = w; v.addr = a; v.wdata = d; v.btn = b; v.sw = s;
    v.chk_q = c; v.exp_q = q; v.exp_ram_wren = rw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge; combinational outputs are valid #1 later.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    bus.wren = w; bus.address_dmem = a; bus.data = d; bus.cmd_ready = rdy;
    #1;
  endtask

  // Let the rising edge happen; registered outputs are sampled #1 after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    vecs.push_back(mk("idle_ram",    0, 100,  0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnc_pulse",  0, 100,  0, 5'b00001, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnc_rd1",    0, 1000, 0, 5'b00000, 4'h0, 1, 32'h1,  0));
    vecs.push_back(mk("btnc_rd2",    0, 1000, 0, 5'b00000, 4'h0, 1, 32'h0,  0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("btnl_hold", 0, 100,  0, 5'b00010, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnl_rd1",    0, 3000, 0, 5'b00010, 4'h0, 1, 32'h1,  0));
    vecs.push_back(mk("btnl_rd2",    0, 3000, 0, 5'b00010, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnl_rel",    0, 100,  0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnu_coinc",  0, 5000, 0, 5'b01000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnu_rd",     0, 5000, 0, 5'b00000, 4'h0, 1, 32'h1,  0));
    vecs.push_back(mk("btnu_rd2",    0, 5000, 0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnrd_pulse", 0, 100,  0, 5'b10100, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnr_rd",     0, 4000, 0, 5'b00000, 4'h0, 1, 32'h1,  0));
    vecs.push_back(mk("btnd_rd",     0, 6000, 0, 5'b00000, 4'h0, 1, 32'h1,  0));
    vecs.push_back(mk("btnl_none",   0, 3000, 0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("btnc_none",   0, 1000, 0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("ram_st",      1, 12, 32'h55, 5'b00000, 4'h0, 0, 32'h0, 1));
    vecs.push_back(mk("ram_ld",      0, 12,   0, 5'b00000, 4'h0, 1, 32'h55, 0));
    vecs.push_back(mk("st_out",      1, 2000, 32'h99, 5'b00000, 4'h0, 0, 32'h0, 0));
    vecs.push_back(mk("st_btnc",     1, 1000, 32'h1,  5'b00000, 4'h0, 0, 32'h0, 0));
    vecs.push_back(mk("st_stat",     1, 2001, 32'h7,  5'b00000, 4'h0, 0, 32'h0, 0));
    vecs.push_back(mk("btnc_clean",  0, 1000, 0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("stat_empty",  0, 2001, 0, 5'b00000, 4'h0, 1, 32'h0,  0));
    vecs.push_back(mk("sw_a",        0, 7000, 0, 5'b00000, 4'hA, 1, 32'hA,  0));
    vecs.push_back(mk("sw_5",        0, 7000, 0, 5'b00000, 4'h5, 1, 32'h5,  0));
    vecs.push_back(mk("ram_after",   0, 12,   0, 5'b00000, 4'h0, 1, 32'h55, 0));

    // ---------------- reset ----------------
    rst = 1'b1;
    bus.btn_c = 0; bus.btn_l = 0; bus.btn_r = 0; bus.btn_u = 0; bus.btn_d = 0;
    bus.sw = '0; bus.address_dmem = 32'd100; bus.wren = 0; bus.data = '0; bus.cmd_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q_dmem",    bus.q_dmem, 32'h0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
    chk("rst_cmd_data",  bus.cmd_data, 32'h0);
    rst = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[k]) begin
      @(negedge clk);
      bus.wren = vecs[k].wren; bus.address_dmem = vecs[k].addr; bus.data = vecs[k].wdata;
      {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l, bus.btn_c} = vecs[k].btn;
      bus.sw = vecs[k].sw; bus.cmd_ready = 1'b1;
      #1;
      chk({vecs[k].name, "_ram_wren"}, 32'(bus.ram_wren), 32'(vecs[k].exp_ram_wren));
      step();
      if (vecs[k].chk_q) chk({vecs[k].name, "_q"}, bus.q_dmem, vecs[k].exp_q);
    end
    {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l, bus.btn_c} = 5'b0;

    // ---------------- overflow then drain ----------------
    for (int k = 0; k < 5; k++) begin
      drive(1, 2000, 32'hA + k, 0);
      chk("ovf_st_ram_wren", 32'(bus.ram_wren), 32'h0);
      step();
    end
    drive(0, 100, 0, 0);
    chk("ovf_valid", 32'(bus.cmd_valid), 32'h1);
    chk("ovf_head",  bus.cmd_data, 32'hA);
    step();
    drive(0, 2001, 0, 0); step();
    chk("ovf_stat1", bus.q_dmem, 32'h0000_8004);
    drive(0, 2001, 0, 0); step();
    chk("ovf_stat2", bus.q_dmem, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      drive(0, 100, 0, 1);
      chk("ovf_drain", bus.cmd_data, 32'hA + k);
      step();
    end
    drive(0, 2001, 0, 1);
    chk("ovf_empty_valid", 32'(bus.cmd_valid), 32'h0);
    step();
    chk("ovf_stat_empty", bus.q_dmem, 32'h0);

    // ---------------- push while full with pop ----------------
    for (int k = 1; k <= 4; k++) begin
      drive(1, 2000, k, 0); step();
    end
    drive(1, 2000, 5, 1);
    chk("fullpop_head", bus.cmd_data, 32'h1);
    step();
    drive(0, 2001, 0, 0); step();
    chk("fullpop_stat", bus.q_dmem, 32'h0000_0004);
    for (int k = 2; k <= 5; k++) begin
      drive(0, 100, 0, 1);
      chk("fullpop_drain", bus.cmd_data, k);
      step();
    end

    // ---------------- push+ready on empty ----------------
    drive(1, 2000, 32'h77, 1);
    chk("emptypush_valid0", 32'(bus.cmd_valid), 32'h0);
    step();
    drive(0, 2001, 0, 0); step();
    chk("emptypush_stat", bus.q_dmem, 32'h0000_0001);
    drive(0, 100, 0, 1);
    chk("emptypush_head", bus.cmd_data, 32'h77);
    step();
    chk("emptypush_drained", 32'(bus.cmd_valid), 32'h0);

    // ---------------- reset during drain ----------------
    bus.btn_c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 2000, 32'h30 + k, 0); step();
      bus.btn_c = 1'b0;
    end
    drive(0, 2001, 0, 1); step();
    chk("drain_stat", bus.q_dmem, 32'h0000_0003);
    bus.sw = 4'hA;
    drive(0, 7000, 0, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_drain_valid", 32'(bus.cmd_valid), 32'h0);
    chk("rst_drain_data",  bus.cmd_data, 32'h0);
    chk("rst_drain_q",     bus.q_dmem, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1000, 0, 1); step();
    chk("rst_pending_lost", bus.q_dmem, 32'h0);
    drive(0, 2001, 0, 1); step();
    chk("rst_stat", bus.q_dmem, 32'h0);
    drive(0, 7000, 0, 1); step();
    chk("rst_sw_alive", bus.q_dmem, 32'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
